// File: rtl/router_pkg.sv
// Shared router definitions: the source-tag encoding (also used as the demux selector)
// and the merge arbiter's FSM states.
package router_pkg;

  localparam logic [1:0] SRC_PORT0 = 2'b00;
  localparam logic [1:0] SRC_PORT1 = 2'b01;
  localparam logic [1:0] SRC_NONE  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  function automatic logic [1:0] src_of(input logic port);
    return port ? SRC_PORT1 : SRC_PORT0;
  endfunction

endpackage

// File: rtl/merge_out_reg.sv
// Registered output stage of the merger: holds data/valid/last/src under ready/valid
// handshaking, and drops the tag back to "none" once a word drains with nothing behind it.
module merge_out_reg
  import router_pkg::*;
#(
  parameter int size = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [size-1:0] load_data,
  input  logic            load_last,
  input  logic [1:0]      load_src,
  input  logic            ready_out,
  output logic [size-1:0] data_out,
  output logic            valid_out,
  output logic            last_out,
  output logic [1:0]      src_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      src_out   <= SRC_NONE;
    end else if (load) begin
      data_out  <= load_data;
      valid_out <= 1'b1;
      last_out  <= load_last;
      src_out   <= load_src;
    end else if (valid_out && ready_out) begin
      // data_out is deliberately left holding the drained word
      valid_out <= 1'b0;
      last_out  <= 1'b0;
      src_out   <= SRC_NONE;
    end
  end

endmodule

// File: rtl/merge_arbiter.sv
// Two-to-one packet merger: round-robin at packet granularity, the owning port streams
// until its last beat, with one IDLE bubble between packets.
module merge_arbiter
  import router_pkg::*;
#(
  parameter int size = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [size-1:0] data0,
  input  logic            valid0,
  input  logic            last0,
  output logic            ready0,
  input  logic [size-1:0] data1,
  input  logic            valid1,
  input  logic            last1,
  output logic            ready1,
  output logic [size-1:0] dataOut,
  output logic            validOut,
  output logic            lastOut,
  output logic [1:0]      srcOut,
  input  logic            readyOut,
  output logic            busy
);

  state_t state, state_next;
  logic   last_grant, last_grant_next;
  logic   slot_free;
  logic   accept0, accept1;

  // Combinational readyOut -> readyx path lets a draining word be replaced in the same cycle
  assign slot_free = ~validOut | readyOut;
  assign ready0    = (state == ST_OWN0) & slot_free;
  assign ready1    = (state == ST_OWN1) & slot_free;
  assign accept0   = valid0 & ready0;
  assign accept1   = valid1 & ready1;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      ST_IDLE: begin
        if (valid0 && valid1)
          state_next = last_grant ? ST_OWN0 : ST_OWN1;
        else if (valid0)
          state_next = ST_OWN0;
        else if (valid1)
          state_next = ST_OWN1;
      end
      ST_OWN0: begin
        if (accept0 && last0) begin
          state_next      = ST_IDLE;
          last_grant_next = 1'b0;
        end
      end
      ST_OWN1: begin
        if (accept1 && last1) begin
          state_next      = ST_IDLE;
          last_grant_next = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  merge_out_reg #(.size(size)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept0 | accept1),
    .load_data (accept1 ? data1 : data0),
    .load_last (accept1 ? last1 : last0),
    .load_src  (src_of(accept1)),
    .ready_out (readyOut),
    .data_out  (dataOut),
    .valid_out (validOut),
    .last_out  (lastOut),
    .src_out   (srcOut)
  );

endmodule

// File: tb/tb_merge_arbiter.sv
// Bench for merge_arbiter: queue-fed port drivers, a packet-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_merge_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] data0 = '0, data1 = '0;
  logic       valid0 = 1'b0, last0 = 1'b0, valid1 = 1'b0, last1 = 1'b0;
  logic       readyOut = 1'b1;
  logic       ready0, ready1, validOut, lastOut, busy;
  logic [1:0] dataOut, srcOut;

  merge_arbiter #(.size(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .data0(data0), .valid0(valid0), .last0(last0), .ready0(ready0),
    .data1(data1), .valid1(valid1), .last1(last1), .ready1(ready1),
    .dataOut(dataOut), .validOut(validOut), .lastOut(lastOut), .srcOut(srcOut),
    .readyOut(readyOut), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] ov(input logic v, input logic l, input logic [1:0] s,
                                    input logic [1:0] d);
    return {v, l, s, 2'b00, d};
  endfunction

  // ---------------- port drivers ----------------
  typedef struct {
    logic [1:0] d;
    logic       l;
    int         gap;   // idle cycles presented before this beat
  } beat_t;
  beat_t q0[$], q1[$];
  logic  acc0 = 1'b0, acc1 = 1'b0;

  always @(negedge clk) begin
    acc0 <= valid0 && ready0;
    acc1 <= valid1 && ready1;
  end

  initial begin
    beat_t b;
    forever begin
      @(posedge clk); #2;
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0 && q0[0].gap > 0) begin
        b = q0[0]; b.gap--; q0[0] = b; valid0 = 1'b0; last0 = 1'b0;
      end else if (q0.size() > 0) begin
        valid0 = 1'b1; data0 = q0[0].d; last0 = q0[0].l;
      end else begin
        valid0 = 1'b0; last0 = 1'b0;
      end
      if (q1.size() > 0 && q1[0].gap > 0) begin
        b = q1[0]; b.gap--; q1[0] = b; valid1 = 1'b0; last1 = 1'b0;
      end else if (q1.size() > 0) begin
        valid1 = 1'b1; data1 = q1[0].d; last1 = q1[0].l;
      end else begin
        valid1 = 1'b0; last1 = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // owner: -1 none, else port number; pref: port that wins the next tie
  int         owner = -1;
  int         pref = 0;
  logic       m_valid = 1'b0, m_last = 1'b0;
  logic [1:0] m_data = '0, m_src = 2'b11;
  logic       m_free, exp_r0, exp_r1;
  int         m_took;

  assign m_free = !m_valid || readyOut;
  assign m_took = (owner == 0 && valid0 && m_free) ? 0 :
                  (owner == 1 && valid1 && m_free) ? 1 : -1;
  assign exp_r0 = (owner == 0) && m_free;
  assign exp_r1 = (owner == 1) && m_free;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= -1; pref <= 0;
      m_valid <= 1'b0; m_last <= 1'b0; m_data <= '0; m_src <= 2'b11;
    end else begin
      if (m_took >= 0) begin
        m_valid <= 1'b1;
        m_data  <= (m_took == 1) ? data1 : data0;
        m_last  <= (m_took == 1) ? last1 : last0;
        m_src   <= (m_took == 1) ? 2'b01 : 2'b00;
      end else if (m_valid && readyOut) begin
        m_valid <= 1'b0; m_last <= 1'b0; m_src <= 2'b11;
      end
      if (owner < 0) begin
        if (valid0 && valid1) owner <= pref;
        else if (valid0)      owner <= 0;
        else if (valid1)      owner <= 1;
      end else if (m_took >= 0 && ((m_took == 1) ? last1 : last0)) begin
        owner <= -1;
        pref  <= 1 - owner;
      end
    end
  end

  always @(negedge clk) begin
    check("model_ready", {6'b0, ready1, ready0}, {6'b0, exp_r1, exp_r0});
    check("model_out", ov(validOut, lastOut, srcOut, dataOut), ov(m_valid, m_last, m_src, m_data));
    check("model_busy", {7'b0, busy}, {7'b0, owner >= 0});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  task automatic negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push0(input logic [1:0] d, input logic l, input int gap);
    beat_t b; b.d = d; b.l = l; b.gap = gap; q0.push_back(b);
  endtask

  task automatic push1(input logic [1:0] d, input logic l, input int gap);
    beat_t b; b.d = d; b.l = l; b.gap = gap; q1.push_back(b);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset held from time 0
    negs(1);
    check("rst_out", ov(validOut, lastOut, srcOut, dataOut), ov(1'b0, 1'b0, 2'b11, 2'b00));
    check("rst_ready_busy", {5'b0, busy, ready1, ready0}, 8'h00);
    next_cycle(); rst_n = 1'b1;

    // single port, 3-beat packet; push marks the start of cycle N
    next_cycle();
    push0(2'd1, 1'b0, 0); push0(2'd2, 1'b0, 0); push0(2'd3, 1'b1, 0);
    negs(2);                                                           // N+1
    check("single_ready0", {7'b0, ready0}, 8'd1);
    negs(1);                                                           // N+2
    check("single_b1", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b00, 2'd1));
    negs(1);
    check("single_b2", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b00, 2'd2));
    negs(1);                                                           // N+4
    check("single_b3", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b00, 2'd3));
    check("single_busy_low", {7'b0, busy}, 8'd0);
    repeat (3) next_cycle();

    // tie after a fresh reset: port 0 first, then alternating every 2 cycles
    rst_n = 1'b0; next_cycle(); rst_n = 1'b1;
    next_cycle();
    push0(2'd2, 1'b1, 0); push0(2'd2, 1'b1, 0);
    push1(2'd3, 1'b1, 0); push1(2'd3, 1'b1, 0);
    negs(3);                                                           // N+2
    check("tie_1", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b00, 2'd2));
    check("tie_bubble_busy", {7'b0, busy}, 8'd0);
    negs(1);
    check("tie_gap", {6'b0, srcOut}, {6'b0, 2'b11});
    negs(1);                                                           // N+4
    check("tie_2", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b01, 2'd3));
    negs(2);
    check("tie_3", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b00, 2'd2));
    negs(2);                                                           // N+8
    check("tie_4", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b01, 2'd3));
    repeat (4) next_cycle();

    // backpressure: readyOut low for cycles N+2..N+4 of a 4-beat port-1 packet
    push1(2'd1, 1'b0, 0); push1(2'd2, 1'b0, 0); push1(2'd3, 1'b0, 0); push1(2'd0, 1'b1, 0);
    @(posedge clk); @(posedge clk); #1; readyOut = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b01, 2'd1));
      check("bp_ready1_low", {7'b0, ready1}, 8'd0);
    end
    next_cycle(); readyOut = 1'b1;
    negs(1);                                                           // N+5
    check("bp_release_ready", {7'b0, ready1}, 8'd1);
    negs(1);
    check("bp_b2", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b01, 2'd2));
    negs(1);
    check("bp_b3", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b01, 2'd3));
    negs(1);
    check("bp_b4", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b01, 2'd0));
    repeat (4) next_cycle();

    // owner stall: port 1 owns, drops valid for 4 cycles while port 0 waits
    push1(2'd1, 1'b0, 0); push1(2'd2, 1'b0, 4); push1(2'd3, 1'b1, 0);
    next_cycle();
    push0(2'd2, 1'b1, 0);
    negs(2);                                                           // N+2
    check("stall_b1", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b01, 2'd1));
    negs(1);
    check("stall_drained", ov(validOut, lastOut, srcOut, dataOut), ov(1'b0, 1'b0, 2'b11, 2'd1));
    negs(1);                                                           // N+4
    check("stall_busy", {6'b0, busy, ready0}, 8'b0000_0010);
    negs(3);                                                           // N+7
    check("stall_b2", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b01, 2'd2));
    negs(1);
    check("stall_b3", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b01, 2'd3));
    check("stall_release", {7'b0, busy}, 8'd0);
    negs(2);                                                           // N+10
    check("stall_p0", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b00, 2'd2));
    repeat (4) next_cycle();

    // reset mid-packet after beat 2 of 4 reaches the output
    push0(2'd0, 1'b0, 0); push0(2'd1, 1'b0, 0); push0(2'd2, 1'b0, 0); push0(2'd3, 1'b1, 0);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;                // N+3
    check("mid_b2", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b0, 2'b00, 2'd1));
    #2; rst_n = 1'b0; #1;
    check("mid_rst_out", ov(validOut, lastOut, srcOut, dataOut), ov(1'b0, 1'b0, 2'b11, 2'd0));
    check("mid_rst_ctl", {5'b0, busy, ready1, ready0}, 8'h00);
    q0.delete(); q1.delete();
    next_cycle(); rst_n = 1'b1;
    next_cycle();
    push0(2'd1, 1'b1, 0); push1(2'd2, 1'b1, 0);
    negs(3);
    check("post_rst_tie0", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b00, 2'd1));
    negs(2);
    check("post_rst_tie1", ov(validOut, lastOut, srcOut, dataOut), ov(1'b1, 1'b1, 2'b01, 2'd2));
    repeat (4) next_cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/merge_arbiter.md
# merge_arbiter

Two-to-one packet merger for the router's stage-2 datapath: the return-direction counterpart of the stage-2 demultiplexer. It collects packets from two input channels, arbitrates round-robin at packet granularity, and drives one registered output channel. A `srcOut` tag uses the same 2-bit selector encoding the demultiplexer consumes, so a merged stream can be re-split downstream.

## Interface
Parameters:
- `size`, default 2: data word width, applies to all data ports.

Ports:
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `data0`, input, `size`: port-0 data word.
- `valid0`, input, 1: port-0 word valid.
- `last0`, input, 1: port-0 word is the final beat of its packet.
- `ready0`, output, 1: port-0 word accepted when `valid0 && ready0`.
- `data1`, `valid1`, `last1`, input: port-1 data, valid and last, same meaning as port 0.
- `ready1`, output, 1: port-1 word accepted when `valid1 && ready1`.
- `dataOut`, output, `size`: registered output word.
- `validOut`, output, 1: output word valid.
- `lastOut`, output, 1: output word is the final beat of its packet.
- `srcOut`, output, 2: source of the output word. 00 = port 0, 01 = port 1, 11 = none.
- `readyOut`, input, 1: downstream accepts the output word when `validOut && readyOut`.
- `busy`, output, 1: high whenever the FSM is not IDLE.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN0: port 0 holds the output until its last beat.
  - OWN1: port 1 holds the output until its last beat.
- Round-robin pointer `lastGrant` is 1 bit. Reset value is 1, so port 0 wins the first tie.
- IDLE transitions:
  - Only `valid0` high: go to OWN0.
  - Only `valid1` high: go to OWN1.
  - Both high: grant the port that is not `lastGrant`.
  - Neither high: stay in IDLE.
  - `ready0` and `ready1` are both 0 while in IDLE.
- OWNx behaviour:
  - `readyx = ~validOut | readyOut`.
  - The non-owner's ready is always 0.
  - On an accepted beat, the output register loads `dataOut`, `lastOut` and `srcOut` from port x, and sets `validOut`.
  - If the accepted beat had `last` = 1: go to IDLE and set `lastGrant` = x.
- Output register:
  - When `validOut && readyOut` and no new beat loads in that cycle, clear `validOut`.
  - When `validOut && readyOut` and no new beat loads, also set `srcOut` to 11 and `lastOut` to 0.
  - `dataOut` holds its last value.
  - While `validOut && ~readyOut`, `dataOut`, `lastOut` and `srcOut` are stable.
- The owner deasserting valid mid-packet does not release ownership; the FSM waits indefinitely in OWNx.
- A packet is never interleaved with the other port's beats.
- Reset (any time, including mid-packet) takes effect immediately:
  - State IDLE, `lastGrant` = 1.
  - `validOut` = 0, `lastOut` = 0, `srcOut` = 11, `dataOut` = 0.
  - `ready0` = `ready1` = 0, `busy` = 0.
  - A partial packet is discarded with no `lastOut`.

## Timing
- Request to first acceptance: valid seen in IDLE at cycle N, grant registered at N+1, `readyx` high and first beat accepted at N+1.
- First beat appears on `dataOut` at N+2. Input-to-output latency is 1 cycle per beat after the grant.
- Within a packet: one beat per cycle while `readyOut` = 1.
- Between packets: exactly one IDLE cycle (inter-packet bubble). Single-beat packets from alternating ports therefore sustain 1 beat per 2 cycles.
- Backpressure: `readyOut` low with `validOut` high forces `readyx` low in the same cycle (combinational path from `readyOut` to `readyx`).
- Release: `last` accepted at cycle M gives `busy` low at M+1. A new grant can occur at M+2.

## Structure
- Shared package `router_pkg` holds:
  - `SRC_PORT0` = 2'b00, `SRC_PORT1` = 2'b01, `SRC_NONE` = 2'b11. These values are shared with the demultiplexer selector.
  - FSM state encoding constants `ST_IDLE`, `ST_OWN0`, `ST_OWN1`.
- One sub-module: `merge_out_reg`, the output register holding data, valid, last and src with the ready/valid hold logic.
- The FSM and round-robin pointer live in `merge_arbiter`.

## Test plan
- **Reset values:** assert `rst_n` low mid-cycle -> immediately `validOut`=0, `srcOut`=11, `ready0`=`ready1`=0, `busy`=0.
- **Single port:** `valid0`=1, 3-beat packet 1,2,3 with `last` on beat 3, `readyOut`=1 -> `dataOut` 1,2,3 at cycles N+2..N+4, `srcOut`=00, `lastOut` only on beat 3, `busy` low at N+4.
- **Tie after reset:** both ports hold 1-beat packets continuously (port 0 = 2, port 1 = 3) -> output sequence 2(00), 3(01), 2(00), 3(01), each 2 cycles apart.
- **Backpressure:** `readyOut`=0 for 3 cycles mid-packet -> `dataOut`/`srcOut` stable, owner ready low. On release, the next beat appears the following cycle with no loss or duplication.
- **Owner stall:** port 1 owns and drops `valid1` for 4 cycles while `valid0`=1 -> no port-0 beats emitted until port 1's `last` is accepted.
- **Reset mid-packet:** reset after beat 2 of 4 -> `validOut` cleared asynchronously. After release, an arbitration tie grants port 0.
